// File: rtl/dpram_pkg.sv
// Shared constants and state encoding for the parametrised dual-port RAM.
package dpram_pkg;
  localparam int READ_BYPASS = 0;
  localparam int READ_PIPE   = 1;

  localparam int WR_NORMAL  = 0;
  localparam int WR_THROUGH = 1;
  localparam int WR_RBW     = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/dpram_port.sv
// One RAM port's read path: read register, write-mode mux, optional output stage.
module dpram_port
  import dpram_pkg::*;
#(
  parameter int DATA_W     = 1,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_MODE  = READ_BYPASS,
  parameter int WRITE_MODE = WR_NORMAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              ce,
  input  logic              wre,
  input  logic              oce,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] dout
);
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_p0;
  logic [DATA_W-1:0] rd_p1;

  assign in_range = 32'(ad) < DEPTH;
  assign rd_word  = in_range ? word : '0;

  // p0: read register, sees the array contents from before this edge's writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p0 <= '0;
    end else if (run && ce) begin
      if (!wre) begin
        rd_p0 <= rd_word;
      end else begin
        case (WRITE_MODE)
          WR_THROUGH: rd_p0 <= din;
          WR_RBW:     rd_p0 <= rd_word;
          default:    rd_p0 <= rd_p0;
        endcase
      end
    end
  end

  // p1: optional output register, only advanced by oce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1 <= '0;
    end else if (run && oce) begin
      rd_p1 <= rd_p0;
    end
  end

  assign dout = (READ_MODE == READ_PIPE) ? rd_p1 : rd_p0;
endmodule

// File: rtl/dpram_param.sv
// Parametrised single-clock true dual-port RAM with a post-reset clear sweep.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int                DATA_W     = 1,
  parameter int                DEPTH      = 32,
  parameter int                ADDR_W     = $clog2(DEPTH),
  parameter int                READ_MODE  = READ_BYPASS,
  parameter int                WRITE_MODE = WR_NORMAL,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cea,
  input  logic              ceb,
  input  logic              wrea,
  input  logic              wreb,
  input  logic              ocea,
  input  logic              oceb,
  input  logic [ADDR_W-1:0] ada,
  input  logic [ADDR_W-1:0] adb,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              init_busy
);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              run;
  logic              a_ok, b_ok;
  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_idx, b_idx;

  assign run   = (state == ST_RUN);
  assign a_ok  = 32'(ada) < DEPTH;
  assign b_ok  = 32'(adb) < DEPTH;
  assign a_idx = a_ok ? ada : '0;
  assign b_idx = b_ok ? adb : '0;
  assign a_we  = run && cea && wrea && a_ok;
  // On a same-address double write port A wins
  assign b_we  = run && ceb && wreb && b_ok && !(a_we && (ada == adb));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= INIT_VALUE;
    end else begin
      if (a_we) mem[a_idx] <= dina;
      if (b_we) mem[b_idx] <= dinb;
    end
  end

  dpram_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_MODE(READ_MODE), .WRITE_MODE(WRITE_MODE)
  ) u_port_a (
    .clk(clk), .reset(reset), .run(run), .ce(cea), .wre(wrea), .oce(ocea),
    .ad(ada), .din(dina), .word(mem[a_idx]), .dout(douta)
  );

  dpram_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_MODE(READ_MODE), .WRITE_MODE(WRITE_MODE)
  ) u_port_b (
    .clk(clk), .reset(reset), .run(run), .ce(ceb), .wre(wreb), .oce(oceb),
    .ad(adb), .din(dinb), .word(mem[b_idx]), .dout(doutb)
  );
endmodule

// File: tb/tb_dpram_param.sv
// Directed bench: six RAM configurations driven by one shared stimulus stream.
module tb_dpram_param;
  logic       clk = 1'b0;
  logic       reset;
  logic       cea, ceb, wrea, wreb, ocea, oceb;
  logic [4:0] ada, adb;
  logic [7:0] dina, dinb;
  logic [5:0] busy;
  logic       da0, db0;
  logic [7:0] da1, db1, da2, db2, da3, db3, da4, db4, da5, db5;
  int         passed = 0;
  int         total = 0;
  int         fall [6];

  always #5 clk = ~clk;

  // u0: 32x1 init 1; u1..u3: 32x8 write modes 0/1/2; u4: pipelined; u5: depth 20
  dpram_param #(.DATA_W(1), .DEPTH(32), .INIT_VALUE(1'b1)) u0 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina[0]), .dinb(dinb[0]),
    .douta(da0), .doutb(db0), .init_busy(busy[0]));
  dpram_param #(.DATA_W(8), .DEPTH(32), .WRITE_MODE(0)) u1 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
    .douta(da1), .doutb(db1), .init_busy(busy[1]));
  dpram_param #(.DATA_W(8), .DEPTH(32), .WRITE_MODE(1)) u2 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
    .douta(da2), .doutb(db2), .init_busy(busy[2]));
  dpram_param #(.DATA_W(8), .DEPTH(32), .WRITE_MODE(2)) u3 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
    .douta(da3), .doutb(db3), .init_busy(busy[3]));
  dpram_param #(.DATA_W(8), .DEPTH(32), .READ_MODE(1)) u4 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
    .douta(da4), .doutb(db4), .init_busy(busy[4]));
  dpram_param #(.DATA_W(8), .DEPTH(20)) u5 (
    .clk(clk), .reset(reset), .cea(cea), .ceb(ceb), .wrea(wrea), .wreb(wreb),
    .ocea(ocea), .oceb(oceb), .ada(ada), .adb(adb), .dina(dina), .dinb(dinb),
    .douta(da5), .doutb(db5), .init_busy(busy[5]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cea = 1'b0; ceb = 1'b0; wrea = 1'b0; wreb = 1'b0;
  endtask

  // Counts edges until each instance drops init_busy; 0 means it never did
  task automatic wait_sweep();
    for (int k = 0; k < 6; k++) fall[k] = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      for (int k = 0; k < 6; k++)
        if (fall[k] == 0 && !busy[k]) fall[k] = i;
    end
  endtask

  initial begin
    reset = 1'b1; idle(); ocea = 1'b0; oceb = 1'b0;
    ada = '0; adb = '0; dina = '0; dinb = '0;
    #12;
    check("reset_busy", {2'b0, busy}, 8'h3F);
    check("reset_douta", da1, 8'h00);
    check("reset_doutb_pipe", db4, 8'h00);

    step(); reset = 1'b0;
    wait_sweep();
    check("sweep_len_d32", 8'(fall[0]), 8'd32);
    check("sweep_len_u1", 8'(fall[1]), 8'd32);
    check("sweep_len_u4", 8'(fall[4]), 8'd32);
    check("sweep_len_d20", 8'(fall[5]), 8'd20);

    // Every word of the 32x1 instance was cleared to 1
    for (int i = 0; i < 32; i++) begin
      cea = 1'b1; ada = 5'(i);
      step();
      check("init_value_read", {7'b0, da0}, 8'h01);
    end

    // Write on A, read back on B the following cycle
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd3; dina = 8'hA5;
    step();
    idle(); ceb = 1'b1; adb = 5'd3;
    step();
    check("b_read_after_a_write_u0", {7'b0, db0}, 8'h01);
    check("b_read_after_a_write_u1", db1, 8'hA5);
    check("b_read_after_a_write_u2", db2, 8'hA5);
    check("b_read_after_a_write_u3", db3, 8'hA5);
    check("b_read_pipe_oce_low", db4, 8'h00);
    check("b_read_after_a_write_d20", db5, 8'hA5);

    // Write modes: preload register with 0x77, then write 0x3C over 0x11
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd6; dina = 8'h77;
    step();
    idle(); cea = 1'b1; ada = 5'd6;
    step();
    check("preload_read", da1, 8'h77);
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd5; dina = 8'h11;
    step();
    idle(); cea = 1'b1; ada = 5'd6;
    step();
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd5; dina = 8'h3C;
    step();
    check("wmode_normal", da1, 8'h77);
    check("wmode_through", da2, 8'h3C);
    check("wmode_rbw", da3, 8'h11);

    // Same-address double write: A's data is kept
    idle(); cea = 1'b1; ceb = 1'b1; wrea = 1'b1; wreb = 1'b1;
    ada = 5'd7; adb = 5'd7; dina = 8'h01; dinb = 8'h02;
    step();
    check("collide_through_a", da2, 8'h01);
    check("collide_through_b", db2, 8'h02);
    idle(); cea = 1'b1; ada = 5'd7;
    step();
    check("collide_a_wins", da1, 8'h01);

    // Read during write from the other port sees the old word
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd9; dina = 8'h99;
    step();
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd9; dina = 8'h55;
    ceb = 1'b1; adb = 5'd9;
    step();
    check("read_during_write_old", db1, 8'h99);
    idle(); ceb = 1'b1; adb = 5'd9;
    step();
    check("read_after_write_new", db1, 8'h55);

    // Pipelined output holds while ocea is low
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd2; dina = 8'h4B;
    step();
    idle(); cea = 1'b1; ada = 5'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pipe_hold_oce_low", da4, 8'h00);
    end
    check("bypass_latency1", da1, 8'h4B);
    ocea = 1'b1;
    step();
    check("pipe_load_oce_high", da4, 8'h4B);
    ocea = 1'b0;

    // Out-of-range on depth 20: write dropped, read returns 0
    idle(); cea = 1'b1; wrea = 1'b1; ada = 5'd25; dina = 8'hEE;
    step();
    idle(); cea = 1'b1; ada = 5'd3;
    step();
    check("d20_in_range_read", da5, 8'hA5);
    idle(); cea = 1'b1; ada = 5'd25;
    step();
    check("d20_out_of_range_read", da5, 8'h00);
    check("d32_addr25_read", da1, 8'hEE);

    // Asynchronous reset clears outputs without a clock edge
    idle();
    #2 reset = 1'b1;
    #1;
    check("async_reset_dout", da1, 8'h00);
    check("async_reset_busy", {2'b0, busy}, 8'h3F);
    step(); reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_sweep_busy", {7'b0, busy[5]}, 8'h01);
    reset = 1'b1;
    step(); reset = 1'b0;
    wait_sweep();
    check("restart_sweep_d20", 8'(fall[5]), 8'd20);
    check("restart_sweep_d32", 8'(fall[1]), 8'd32);
    idle(); cea = 1'b1; ada = 5'd3;
    step();
    check("cleared_after_resweep", da1, 8'h00);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dpram_param.md
# dpram_param

Parametrised true dual-port RAM, single clock, for the bitmap, feature and weight buffers of the digit-recognition pipeline. It generalises the fixed 32×1 dual-port block RAM in three ways: configurable width and depth, a selectable output-register stage and write mode, and a hardware clear sweep after reset so buffers start from a known value. It is the common storage primitive between the capture/downscale stage and the classifier.

## Interface
- `DATA_W`, default 1: word width in bits.
- `DEPTH`, default 32: number of words, ≥ 2; need not be a power of two.
- `ADDR_W`, default `$clog2(DEPTH)`: address width (derived).
- `READ_MODE`, default 0: 0 = bypass (1-cycle read); 1 = pipelined (extra output register gated by `oce*`).
- `WRITE_MODE`, default 0: 0 = normal (dout holds); 1 = write-through (dout = din); 2 = read-before-write (dout = old word).
- `INIT_VALUE`, default 0: word written to every address by the clear sweep.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `cea`, `ceb` in 1: port A / port B access enable.
- `wrea`, `wreb` in 1: write enable, qualified by `ce*`.
- `ocea`, `oceb` in 1: output-register enable (READ_MODE=1 only).
- `ada`, `adb` in ADDR_W: addresses.
- `dina`, `dinb` in DATA_W: write data.
- `douta`, `doutb` out DATA_W: read data.
- `init_busy` out 1: clear sweep in progress.

## Operation
- Reset values: `douta`, `doutb`, every pipeline register = 0; `init_busy` = 1; sweep counter = 0.
- FSM states:
  - INIT: write `INIT_VALUE` to address `cnt` each cycle. At `cnt == DEPTH-1`, go to RUN and clear `init_busy`.
  - RUN: normal access.
  - `reset` asserted in any state returns to INIT with `cnt = 0` (sweep restarts from the beginning).
- In INIT, `ce*`, `wre*` and `oce*` are ignored, and `dout*` stays 0.
- Access (RUN), per port: `ce=1, wre=0` reads `mem[ad]`. `ce=1, wre=1` writes `din` and updates the read register according to WRITE_MODE. `ce=0` leaves the read register unchanged.
- Out-of-range address (`ad >= DEPTH`): the write is dropped and the read returns 0.
- Same-address write collision, both ports in the same cycle: port A's data is stored and port B's write is lost. Each port's dout still follows its own WRITE_MODE rule.
- Read on one port while the other writes the same address in the same cycle: the reader gets the old word. The new word is visible from the next cycle.

## Timing
- READ_MODE=0: `dout` is valid on the first rising edge after the `ce` cycle (latency 1).
- READ_MODE=1: the second stage loads on an edge where `oce=1` and holds otherwise (latency 2 with `oce` held high).
- Write latency: a write on edge N is readable by either port with `ce` on edge N+1.
- Sweep length: exactly DEPTH cycles. `init_busy` falls on the edge that writes address DEPTH-1, and the first accepted access is in the following cycle.
- `reset` is asynchronous: `dout*` go to 0 and `init_busy` to 1 immediately, independent of `clk`.

## Structure
- Shared package `dpram_pkg` holds:
  - `READ_BYPASS=0`, `READ_PIPE=1`;
  - `WR_NORMAL=0`, `WR_THROUGH=1`, `WR_RBW=2`;
  - the state enum `{ST_INIT, ST_RUN}`.
- The memory array, sweep counter/FSM and collision arbitration live in the top-level module.
- Sub-module `dpram_port` is instantiated twice. It holds the per-port read register, WRITE_MODE mux, optional output stage and out-of-range masking.

## Test plan
- Reset, DEPTH=32, INIT_VALUE=1 -> `init_busy` high for exactly 32 cycles. Reads of addresses 0..31 then all return 1.
- DATA_W=8, READ_MODE=0: A writes 0xA5 at address 3; next cycle B reads address 3 -> `doutb`=0xA5 one cycle after `ceb`.
- WRITE_MODE 0/1/2, A writes 0x3C over 0x11 at address 5 -> `douta` is respectively the previous register value, 0x3C, 0x11.
- Both ports write address 7 in the same cycle (A=0x01, B=0x02) -> subsequent read gives 0x01. B reads address 9 while A writes 0x55 there -> B gets the old word, and 0x55 on the next read.
- READ_MODE=1: read address 2 with `ocea` low for 3 cycles, then high -> `douta` holds 0 and updates on the first edge after `ocea` rises.
- DEPTH=20: write address 25 -> dropped, and reading 25 returns 0. Assert `reset` at sweep cycle 10 -> the sweep restarts and `init_busy` lasts 20 further cycles.
